// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// Defining FAST_READ_EN selects the 0x0B fast-read frame with one dummy byte after the address.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER,
    WAIT_CS
  } state_e;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  // sys_clk cycles per serial byte on the driver side
  localparam int unsigned BYTE_CLKS = 32;

`ifdef FAST_READ_EN
  localparam bit          FAST_READ = 1'b1;
  localparam int unsigned HDR_LEN   = 5;
`else
  localparam bit          FAST_READ = 1'b0;
  localparam int unsigned HDR_LEN   = 4;
`endif

endpackage

// File: rtl/spi_flash_read_ctrl.sv
// Serial-flash READ frame sequencer driving a mode-0 SPI byte driver: opcode, 24-bit address, N data bytes.
// FAST_READ_EN (see spi_flash_pkg) switches to the fast-read opcode with one dummy header byte.
module spi_flash_read_ctrl
  import spi_flash_pkg::*;
#(
  parameter int         LEN_W     = 8,
  parameter logic [7:0] READ_OP   = OP_READ,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             rd_req,
  input  logic [23:0]      rd_addr,
  input  logic [LEN_W-1:0] rd_len,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_done,
  output logic             spi_start,
  output logic             spi_end,
  output logic [7:0]       data_send,
  input  logic [7:0]       data_rec,
  input  logic             send_done,
  input  logic             rec_done,
  input  logic             spi_cs
);

  localparam int         CNT_W  = LEN_W + 3;
  localparam logic [7:0] OPCODE = FAST_READ ? OP_FAST_READ : READ_OP;

  state_e             state_q, state_d;
  logic [23:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   tx_idx_q, tx_idx_d;
  logic [CNT_W-1:0]   rx_idx_q, rx_idx_d;
  logic [7:0]         data_send_q, data_send_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_done_q, rd_done_d;
  logic               busy_q, busy_d;
  logic               spi_end_q, spi_end_d;
  logic [CNT_W-1:0]   last_idx;

  // Index of the final byte of the frame (header plus data).
  assign last_idx = CNT_W'(HDR_LEN) + CNT_W'(len_q) - CNT_W'(1);

  // Byte to load after byte idx-1 has been launched; index 0 (opcode) is loaded on request.
  function automatic logic [7:0] tx_byte(input logic [CNT_W-1:0] idx, input logic [23:0] addr);
    if (idx == CNT_W'(1)) return addr[23:16];
    if (idx == CNT_W'(2)) return addr[15:8];
    if (idx == CNT_W'(3)) return addr[7:0];
    return FILL_BYTE;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    tx_idx_d    = tx_idx_q;
    rx_idx_d    = rx_idx_q;
    data_send_d = data_send_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_done_d   = 1'b0;
    busy_d      = busy_q;
    spi_end_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d      = rd_addr;
          len_d       = rd_len;
          busy_d      = 1'b1;
          data_send_d = OPCODE;
          state_d     = START;
        end
      end
      START: begin
        tx_idx_d = '0;
        rx_idx_d = '0;
        state_d  = XFER;
      end
      XFER: begin
        if (send_done) begin
          tx_idx_d    = tx_idx_q + CNT_W'(1);
          data_send_d = tx_byte(tx_idx_q + CNT_W'(1), addr_q);
          // The driver releases CS at the next byte boundary, so only request it on the last byte.
          if (tx_idx_q == last_idx) spi_end_d = 1'b1;
        end
        if (rec_done) begin
          rx_idx_d = rx_idx_q + CNT_W'(1);
          if (rx_idx_q >= CNT_W'(HDR_LEN)) begin
            rd_data_d  = data_rec;
            rd_valid_d = 1'b1;
          end
          if (rx_idx_q == last_idx) state_d = WAIT_CS;
        end
      end
      WAIT_CS: begin
        if (spi_cs) begin
          rd_done_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      tx_idx_q    <= '0;
      rx_idx_q    <= '0;
      data_send_q <= 8'h00;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      spi_end_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      tx_idx_q    <= tx_idx_d;
      rx_idx_q    <= rx_idx_d;
      data_send_q <= data_send_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_done_q   <= rd_done_d;
      busy_q      <= busy_d;
      spi_end_q   <= spi_end_d;
    end
  end

  assign spi_start = (state_q == START);
  assign spi_end   = spi_end_q;
  assign data_send = data_send_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_done   = rd_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Self-checking bench for spi_flash_read_ctrl with a behavioural SPI byte driver and flash model.
// Build with FAST_READ_EN defined to exercise the fast-read frame.
module tb_spi_flash_read_ctrl;
  import spi_flash_pkg::*;

  localparam int LEN_W = 8;
`ifdef FAST_READ_EN
  localparam logic [7:0] EXP_OP  = 8'h0B;
  localparam int         EXP_HDR = 5;
`else
  localparam logic [7:0] EXP_OP  = 8'h03;
  localparam int         EXP_HDR = 4;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             rd_req = 1'b0;
  logic [23:0]      rd_addr = '0;
  logic [LEN_W-1:0] rd_len = '0;
  logic             busy, rd_valid, rd_done, spi_start, spi_end;
  logic [7:0]       rd_data, data_send;
  logic [7:0]       data_rec = 8'h00;
  logic             send_done = 1'b0;
  logic             rec_done = 1'b0;
  logic             spi_cs = 1'b1;

  spi_flash_read_ctrl #(.LEN_W(LEN_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_len    (rd_len),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_done   (rd_done),
    .spi_start (spi_start),
    .spi_end   (spi_end),
    .data_send (data_send),
    .data_rec  (data_rec),
    .send_done (send_done),
    .rec_done  (rec_done),
    .spi_cs    (spi_cs)
  );

  initial forever #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboards: expected MOSI bytes and expected rd_data bytes, in order.
  logic [7:0] mosi_q[$];
  logic [7:0] rd_q[$];

  int n_valid = 0, n_done = 0, n_start = 0, n_end = 0, n_windows = 0, last_win = 0;

  // Driver model state
  bit          drv_active = 1'b0;
  bit          drv_end_req = 1'b0;
  int          drv_phase = 0;
  int          drv_byte = 0;
  int          drv_win = 0;
  logic [23:0] drv_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flash_mem(input logic [23:0] a);
    return a[7:0] + 8'h5B;
  endfunction

  task automatic capture_mosi();
    check("mosi_expected_present", 32'(mosi_q.size() != 0), 32'd1);
    if (mosi_q.size() != 0) check("mosi_byte", 32'(data_send), 32'(mosi_q.pop_front()));
    if (drv_byte == 1) drv_addr[23:16] = data_send;
    if (drv_byte == 2) drv_addr[15:8]  = data_send;
    if (drv_byte == 3) drv_addr[7:0]   = data_send;
  endtask

  // One system clock: sample DUT outputs on the falling edge, then advance the driver model.
  task automatic tick();
    @(negedge sys_clk);
    if (sys_rst_n) begin
      if (spi_start) n_start++;
      if (spi_end)   n_end++;
      if (rd_done)   n_done++;
      if (rd_valid) begin
        n_valid++;
        check("rd_expected_present", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
    end
    send_done = 1'b0;
    rec_done  = 1'b0;
    if (!sys_rst_n) begin
      drv_active = 1'b0;
      spi_cs     = 1'b1;
    end else if (!drv_active) begin
      if (spi_start) begin
        drv_active  = 1'b1;
        drv_end_req = 1'b0;
        spi_cs      = 1'b0;
        drv_phase   = 0;
        drv_byte    = 0;
        drv_win     = 0;
        n_windows++;
        capture_mosi();
      end
    end else begin
      drv_win++;
      drv_phase++;
      if (spi_end) drv_end_req = 1'b1;
      if (drv_phase == 28) send_done = 1'b1;
      if (drv_phase == 31) begin
        rec_done = 1'b1;
        data_rec = (drv_byte >= EXP_HDR) ? flash_mem(drv_addr + 24'(drv_byte - EXP_HDR)) : 8'hEE;
      end
      if (drv_phase == int'(BYTE_CLKS)) begin
        if (drv_end_req) begin
          drv_active = 1'b0;
          spi_cs     = 1'b1;
          last_win   = drv_win;
        end else begin
          drv_byte++;
          drv_phase = 0;
          capture_mosi();
        end
      end
    end
  endtask

  task automatic push_expect(input logic [23:0] addr, input logic [LEN_W-1:0] len);
    mosi_q.push_back(EXP_OP);
    mosi_q.push_back(addr[23:16]);
    mosi_q.push_back(addr[15:8]);
    mosi_q.push_back(addr[7:0]);
    if (EXP_HDR == 5) mosi_q.push_back(8'h00);
    for (int j = 0; j < int'(len); j++) begin
      mosi_q.push_back(8'h00);
      rd_q.push_back(flash_mem(addr + 24'(j)));
    end
  endtask

  // Runs one frame; optionally re-pulses rd_req with different arguments rep_at cycles in.
  task automatic do_frame(input logic [23:0] addr, input logic [LEN_W-1:0] len, input int rep_at);
    int s_start, s_end, s_valid, s_done, total, limit, win_exp;
    bit seen;
    total   = EXP_HDR + int'(len);
    limit   = (total + 3) * int'(BYTE_CLKS);
    win_exp = total * 32;
    s_start = n_start; s_end = n_end; s_valid = n_valid; s_done = n_done;
    push_expect(addr, len);
    rd_addr = addr;
    rd_len  = len;
    rd_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
    rd_addr = 24'h5A5A5A;
    rd_len  = 8'hC3;
    check("busy_after_req", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int cyc = 1; cyc <= limit && !seen; cyc++) begin
      tick();
      rd_req = 1'b0;
      if (n_done != s_done) seen = 1'b1;
      else if (cyc == rep_at) begin
        rd_addr = 24'hABCDEF;
        rd_len  = 8'd5;
        rd_req  = 1'b1;
      end
    end
    check("rd_done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("rd_done_count", 32'(n_done - s_done), 32'd1);
    check("rd_valid_count", 32'(n_valid - s_valid), 32'(len));
    check("spi_start_count", 32'(n_start - s_start), 32'd1);
    check("spi_end_count", 32'(n_end - s_end), 32'd1);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("mosi_q_drained", 32'(mosi_q.size()), 32'd0);
    check("cs_window_len", (last_win >= win_exp - 4 && last_win <= win_exp + 4) ? 32'(win_exp) : 32'(last_win),
          32'(win_exp));
  endtask

  initial begin : stimulus
    int s_done, s_win;
    sys_rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd0);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_end", 32'(spi_end), 32'd0);
    check("rst_data_send", 32'(data_send), 32'h00);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    sys_rst_n = 1'b1;
    repeat (2) tick();

    // Basic read, four data bytes A0..A3
    do_frame(24'h012345, 8'd4, 0);
    repeat (5) tick();

    // Header-only frame at the top of the address space
    do_frame(24'hFFFFFF, 8'd0, 0);
    repeat (5) tick();

    // A second rd_req mid-frame must be ignored
    do_frame(24'h000010, 8'd2, 40);
    repeat (100) tick();
    check("ignored_req_no_frame", 32'(n_start), 32'd3);

    // Reset 100 cycles into an eight-byte frame
    s_done = n_done;
    push_expect(24'h020000, 8'd8);
    rd_addr = 24'h020000;
    rd_len  = 8'd8;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (99) tick();
    sys_rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_spi_start", 32'(spi_start), 32'd0);
    check("midrst_spi_end", 32'(spi_end), 32'd0);
    repeat (3) tick();
    mosi_q.delete();
    rd_q.delete();
    sys_rst_n = 1'b1;
    repeat (50) tick();
    check("midrst_no_rd_done", 32'(n_done - s_done), 32'd0);
    do_frame(24'h100000, 8'd3, 0);
    repeat (5) tick();

    // Back-to-back single-byte frames, second request the cycle after rd_done
    s_win = n_windows;
    do_frame(24'h000200, 8'd1, 0);
    do_frame(24'h000300, 8'd1, 0);
    check("b2b_cs_windows", 32'(n_windows - s_win), 32'd2);
    repeat (5) tick();

    // Fast-read test-plan address (normal read frame when FAST_READ_EN is undefined)
    do_frame(24'h000100, 8'd2, 0);
    repeat (50) tick();
    check("total_rd_done", 32'(n_done), 32'd7);
    check("total_spi_start", 32'(n_start), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_ctrl.md
Name: spi_flash_read_ctrl

Overview:
- Sequencer for the mode-0 SPI byte driver (spi_start/spi_end/data_send/send_done/rec_done). Runs a complete serial-flash READ frame: opcode, 24-bit address, then N data bytes.
- Hands the data bytes to the user side as a valid-strobed stream.
- Sits between the user logic and the SPI byte driver. Both are instantiated side by side in the SPI top level.

Parameters:
- LEN_W, 8: width of rd_len; a frame carries at most 2^LEN_W-1 data bytes.
- READ_OP, 8'h03: opcode for a normal read.
- FILL_BYTE, 8'h00: value driven on data_send during data-phase bytes.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  one-cycle pulse; starts a read frame; sampled only in IDLE
- rd_addr  in  24  flash byte address; captured with rd_req
- rd_len  in  LEN_W  data byte count; captured with rd_req
- busy  out  1  high from the cycle after rd_req acceptance until rd_done
- rd_data  out  8  received data byte
- rd_valid  out  1  one-cycle strobe qualifying rd_data
- rd_done  out  1  one-cycle pulse; frame finished and CS released
- spi_start  out  1  to driver; one-cycle frame-start pulse
- spi_end  out  1  to driver; one-cycle end request
- data_send  out  8  to driver; byte to transmit
- data_rec  in  8  from driver; received byte
- send_done  in  1  from driver; last bit of current byte launched
- rec_done  in  1  from driver; 8th bit sampled, data_rec valid
- spi_cs  in  1  from driver; chip select, low active

Behaviour:
- Reset values: all outputs 0, data_send 8'h00, state IDLE, counters 0. Reset mid-frame aborts immediately with no rd_done. The driver shares the reset.
- Header length HDR = 4 (opcode + 3 address bytes). Total bytes T = HDR + rd_len. A byte takes 32 sys_clk.
- IDLE:
  - rd_req=1 captures rd_addr and rd_len, sets busy next cycle, and goes to START.
  - rd_req while busy=1 is ignored; there is no queueing.
- START:
  - One-cycle spi_start=1 with data_send=READ_OP on the same cycle.
  - Clear tx_idx and rx_idx, then go to XFER.
- XFER, transmit side: on each send_done, tx_idx++ and data_send is updated the same cycle to the next byte:
  - idx1 = addr[23:16]
  - idx2 = addr[15:8]
  - idx3 = addr[7:0]
  - idx ≥ HDR = FILL_BYTE
- XFER, end request: when send_done arrives for byte T-1 (the final byte), spi_end=1 for exactly one cycle. spi_end is never pulsed earlier, because the driver closes CS at the next byte boundary after the request.
- XFER, receive side: on each rec_done, rx_idx++.
  - If rx_idx ≥ HDR, rd_data ← data_rec and rd_valid=1 on the next cycle.
  - Header-phase bytes are discarded.
- XFER → WAIT_CS: transition after rec_done of byte T-1.
- WAIT_CS → IDLE: once spi_cs=1, pulse rd_done and drop busy in the same cycle.
- rd_len=0: frame is header only, zero rd_valid pulses, rd_done still pulses.
- Counters are LEN_W+3 bits wide; no wrap is possible within a frame.
- Simultaneous send_done and rec_done (not produced by the driver) are each handled independently.
- rd_valid count per frame equals rd_len exactly. Bytes leave in address order.

Optional Feature:
- FAST_READ_EN defined:
  - Opcode is 8'h0B instead of READ_OP.
  - HDR = 5: one dummy byte (FILL_BYTE) follows the address; its received byte is discarded.
- FAST_READ_EN undefined: HDR = 4, opcode READ_OP.

Decomposition:
- Package spi_flash_pkg holds:
  - state enum (IDLE, START, XFER, WAIT_CS)
  - opcode constants 8'h03 and 8'h0B
  - HDR_LEN constant
  - byte-time constant 32
- No sub-module. spi_flash_read_ctrl and the byte driver are peers wired in spi_flash_read_top.

Test Plan:
- rd_addr=24'h012345, rd_len=4, flash model returns A0..A3 → MOSI bytes 03 01 23 45 00 00 00 00; rd_data A0,A1,A2,A3 on 4 rd_valid pulses; CS low for 8×32 cycles ±4; a single rd_done.
- rd_len=0, rd_addr=24'hFFFFFF → MOSI 03 FF FF FF; no rd_valid; rd_done after CS rises.
- rd_req pulsed again 40 cycles into a rd_len=2 frame → ignored; exactly one frame and one rd_done; captured addr/len unchanged.
- sys_rst_n low 100 cycles into a rd_len=8 frame → busy, rd_valid, spi_start and spi_end all 0 at once; CS high; no rd_done; the next rd_req runs a clean frame.
- Two back-to-back requests, rd_len=1 each, second issued the cycle after rd_done → two separate CS-low windows, each with exactly one rd_valid.
- FAST_READ_EN, rd_addr=24'h000100, rd_len=2 → MOSI 0B 00 01 00 00 00 00; first 5 received bytes discarded; 2 rd_valid pulses.
